// File: rtl/td4_register_bank.sv
// TD4 architectural state: A, B, output port, program counter and carry flag.
// Captures the adder sum into the selected registers and steps the PC once per enabled cycle.
module td4_register_bank #(
  parameter int unsigned           WIDTH    = 4,
  parameter logic [WIDTH-1:0]      PC_RESET = '0
) (
  input  logic             CLK,
  input  logic             N_RESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] SUM,
  input  logic             CARRY,
  input  logic [3:0]       LOAD,
  output logic [WIDTH-1:0] REG_A,
  output logic [WIDTH-1:0] REG_B,
  output logic [WIDTH-1:0] OUT_PORT,
  output logic [WIDTH-1:0] PC,
  output logic             C_FLAG
);

  logic [WIDTH-1:0] pcNext;

  // The increment wraps naturally; its carry out is dropped and never reaches C_FLAG.
  always_comb begin
    pcNext = PC + WIDTH'(1);
    if (LOAD[3]) begin
      pcNext = SUM;
    end
  end

  always_ff @(posedge CLK) begin
    if (!N_RESET) begin
      REG_A    <= '0;
      REG_B    <= '0;
      OUT_PORT <= '0;
    end else if (CE) begin
      if (LOAD[0]) REG_A    <= SUM;
      if (LOAD[1]) REG_B    <= SUM;
      if (LOAD[2]) OUT_PORT <= SUM;
    end
  end

  // The flag follows the adder carry on every enabled step, independent of LOAD.
  always_ff @(posedge CLK) begin
    if (!N_RESET) begin
      PC     <= PC_RESET;
      C_FLAG <= 1'b0;
    end else if (CE) begin
      PC     <= pcNext;
      C_FLAG <= CARRY;
    end
  end

endmodule

// File: tb/tb_td4_register_bank.sv
// Scoreboard bench for td4_register_bank: stimulus queues expected state,
// a monitor compares it one clock edge later.
module tb_td4_register_bank;

  logic       CLK;
  logic       N_RESET;
  logic       CE;
  logic [3:0] SUM;
  logic       CARRY;
  logic [3:0] LOAD;
  logic [3:0] REG_A;
  logic [3:0] REG_B;
  logic [3:0] OUT_PORT;
  logic [3:0] PC;
  logic       C_FLAG;

  typedef struct {
    string      tag;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] o;
    logic [3:0] pc;
    logic       c;
  } expT;

  expT sbQueue[$];
  int  checkCount = 0;
  int  errorCount = 0;

  td4_register_bank #(.WIDTH(4), .PC_RESET(4'h0)) dut (
    .CLK(CLK), .N_RESET(N_RESET), .CE(CE), .SUM(SUM), .CARRY(CARRY), .LOAD(LOAD),
    .REG_A(REG_A), .REG_B(REG_B), .OUT_PORT(OUT_PORT), .PC(PC), .C_FLAG(C_FLAG)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction step at the falling edge and queue the state expected after the next rising edge.
  task automatic applyStimulus(input string tag, input logic nRst, input logic ce,
                               input logic [3:0] sum, input logic carry, input logic [3:0] load,
                               input logic [3:0] expA, input logic [3:0] expB,
                               input logic [3:0] expO, input logic [3:0] expPc, input logic expC);
    expT e;
    @(negedge CLK);
    N_RESET = nRst;
    CE      = ce;
    SUM     = sum;
    CARRY   = carry;
    LOAD    = load;
    e.tag = tag; e.a = expA; e.b = expB; e.o = expO; e.pc = expPc; e.c = expC;
    sbQueue.push_back(e);
  endtask

  // Every rising edge produces new state, so the monitor pops one entry per edge.
  initial begin
    expT e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        checkOutput({e.tag, ".REG_A"},    REG_A,          e.a);
        checkOutput({e.tag, ".REG_B"},    REG_B,          e.b);
        checkOutput({e.tag, ".OUT_PORT"}, OUT_PORT,       e.o);
        checkOutput({e.tag, ".PC"},       PC,             e.pc);
        checkOutput({e.tag, ".C_FLAG"},   {3'b000, C_FLAG}, {3'b000, e.c});
      end
    end
  end

  initial begin
    N_RESET = 1'b0; CE = 1'b1; SUM = 4'hA; CARRY = 1'b1; LOAD = 4'b1111;

    applyStimulus("reset0", 1'b0, 1'b1, 4'hA, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    applyStimulus("reset1", 1'b0, 1'b1, 4'hA, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    for (int i = 1; i <= 17; i++) begin
      logic [3:0] expPc;
      expPc = 4'(i % 16);
      applyStimulus($sformatf("wrap%0d", i), 1'b1, 1'b1, 4'hA, 1'b0, 4'b0000,
                    4'h0, 4'h0, 4'h0, expPc, 1'b0);
    end

    applyStimulus("loadA",   1'b1, 1'b1, 4'h7, 1'b0, 4'b0001, 4'h7, 4'h0, 4'h0, 4'h2, 1'b0);
    applyStimulus("loadB",   1'b1, 1'b1, 4'h2, 1'b0, 4'b0010, 4'h7, 4'h2, 4'h0, 4'h3, 1'b0);
    applyStimulus("loadOut", 1'b1, 1'b1, 4'h5, 1'b0, 4'b0100, 4'h7, 4'h2, 4'h5, 4'h4, 1'b0);

    applyStimulus("jump",  1'b1, 1'b1, 4'h3, 1'b0, 4'b1000, 4'h7, 4'h2, 4'h5, 4'h3, 1'b0);
    applyStimulus("multi", 1'b1, 1'b1, 4'h9, 1'b0, 4'b1011, 4'h9, 4'h9, 4'h5, 4'h9, 1'b0);

    applyStimulus("carrySet", 1'b1, 1'b1, 4'hE, 1'b1, 4'b0000, 4'h9, 4'h9, 4'h5, 4'hA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("hold%0d", i), 1'b1, 1'b0, 4'h6, 1'b0, 4'b1111,
                    4'h9, 4'h9, 4'h5, 4'hA, 1'b1);
    end
    applyStimulus("carryClr", 1'b1, 1'b1, 4'h6, 1'b0, 4'b0000, 4'h9, 4'h9, 4'h5, 4'hB, 1'b0);

    applyStimulus("prepA",   1'b1, 1'b1, 4'h7, 1'b0, 4'b0001, 4'h7, 4'h9, 4'h5, 4'hC, 1'b0);
    applyStimulus("prepPc",  1'b1, 1'b1, 4'h9, 1'b1, 4'b1000, 4'h7, 4'h9, 4'h5, 4'h9, 1'b1);
    applyStimulus("midRst",  1'b0, 1'b1, 4'h7, 1'b1, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    applyStimulus("postRst", 1'b1, 1'b1, 4'h7, 1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0);

    // Reset must win over a simultaneous CE=0.
    applyStimulus("fillAll", 1'b1, 1'b1, 4'h5, 1'b1, 4'b0111, 4'h5, 4'h5, 4'h5, 4'h2, 1'b1);
    applyStimulus("rstHold", 1'b0, 1'b0, 4'h5, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    begin
      int waitCycles;
      waitCycles = 0;
      while (sbQueue.size() > 0 && waitCycles < 10) begin
        @(posedge CLK);
        #2;
        waitCycles++;
      end
      checkCount++;
      if (sbQueue.size() > 0) begin
        errorCount++;
        $display("[TB] FAIL drain: %0d entries left, expected 0", sbQueue.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
